// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and counter sizing shared by the serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit x - y; ports x, y in; diff = x^y, borrow = ~x&y out
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);
  assign diff   = x ^ y;
  assign borrow = ~x & y;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with borrow-out, one result per WIDTH+2 cycles
// ports: clk, rst (sync active-high), start, a, b in; busy, done (1-cycle), diff, borrow out
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] sa, sb, res, res_next, top_bit;
  logic [CW-1:0]    cnt;
  logic             bff, d0, b0, d_i, b1, bo_i;
  half_subtractor u_hs0 (.x(sa[0]), .y(sb[0]), .diff(d0),  .borrow(b0));
  half_subtractor u_hs1 (.x(d0),    .y(bff),   .diff(d_i), .borrow(b1));
  assign bo_i = b0 | b1;
  // top_bit keeps the shift-in legal for WIDTH=1, where res[WIDTH-1:1] would be empty
  always_comb begin
    top_bit = '0;
    top_bit[WIDTH-1] = d_i;
    res_next = (res >> 1) | top_bit;
  end
  // outputs are loaded on the final RUN edge so they are valid in the same cycle as done
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      bff    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            bff   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          bff <= bo_i;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff   <= res_next;
            borrow <= bo_i;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
